// File: rtl/gpio_bus_bridge_if.sv
// CPU data-bus side of the GPIO bridge.
//   master : CPU / bus fabric (drives select, strobes, address, write data)
//   slave  : gpio_bus_bridge (returns read data and ready)
interface gpio_bus_bridge_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              i_Sel;
  logic              i_WE;
  logic              i_RE;
  logic [ADDR_W-1:0] i_Addr;
  logic [WIDTH-1:0]  i_WData;
  logic [WIDTH-1:0]  o_RData;
  logic              o_Ready;

  modport master (
    output i_Sel, i_WE, i_RE, i_Addr, i_WData,
    input  o_RData, o_Ready
  );

  modport slave (
    input  i_Sel, i_WE, i_RE, i_Addr, i_WData,
    output o_RData, o_Ready
  );
endinterface

// File: rtl/gpio_bus_bridge.sv
// Memory-mapped bridge between the MIPS data bus and the GPIO block.
// Bus accesses complete in one cycle: o_Ready/o_RData are presented the
// cycle after the request edge. DOUT/DDIR writes become one-cycle
// o_WEO/o_WER strobes with data on o_DD. Per-pin edge capture feeds a
// sticky W1C status register and a masked, registered interrupt.
// Ports:
//   i_Clk, i_rst_n : clock, async active-low reset
//   bus            : CPU bus (slave modport)
//   i_DIN, i_DDIR  : pin state and direction from GPIO (DDIR 1 = input)
//   o_DD           : data to GPIO
//   o_WEO, o_WER   : GPIO output / direction register write strobes
//   o_Irq          : level interrupt to CPU

// One pin of edge capture plus its sticky status next-state.
module gpio_edge_lane (
  input  logic primed,
  input  logic din,
  input  logic prev,
  input  logic ddir,
  input  logic rise_en,
  input  logic fall_en,
  input  logic stat,
  input  logic clr,
  output logic stat_d
);
  logic rise, fall;
  always_comb begin
    rise   = primed & din  & ~prev & ddir & rise_en;
    fall   = primed & ~din & prev  & ddir & fall_en;
    // set wins over a coincident W1C
    stat_d = (stat & ~clr) | rise | fall;
  end
endmodule

module gpio_bus_bridge #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_Clk,
  input  logic              i_rst_n,
  gpio_bus_bridge_if.slave  bus,
  input  logic [WIDTH-1:0]  i_DIN,
  input  logic [WIDTH-1:0]  i_DDIR,
  output logic [WIDTH-1:0]  o_DD,
  output logic              o_WEO,
  output logic              o_WER,
  output logic              o_Irq
);
  typedef enum logic [2:0] {
    R_DIN, R_DOUT, R_DDIR, R_RISE, R_FALL, R_STAT, R_MASK, R_NONE
  } reg_e;

  logic             req, wr, rd;
  reg_e             ridx;
  logic [WIDTH-1:0] rd_mux, clr;

  logic [WIDTH-1:0] rdata_d, rdata_q;
  logic             ready_d, ready_q;
  logic [WIDTH-1:0] dd_d, dd_q;
  logic             weo_d, weo_q, wer_d, wer_q;
  logic [WIDTH-1:0] dout_d, dout_q;
  logic [WIDTH-1:0] rise_en_d, rise_en_q;
  logic [WIDTH-1:0] fall_en_d, fall_en_q;
  logic [WIDTH-1:0] stat_d, stat_q;
  logic [WIDTH-1:0] mask_d, mask_q;
  logic [WIDTH-1:0] prev_d, prev_q;
  logic             primed_d, primed_q;
  logic             irq_d, irq_q;

  // byte-lane bits of the address carry no meaning for word registers
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.i_Addr[1:0];

  always_comb begin
    req  = bus.i_Sel & (bus.i_WE | bus.i_RE);
    wr   = req & bus.i_WE;
    rd   = req & ~bus.i_WE;      // WE wins when both strobes are high
    ridx = reg_e'(bus.i_Addr[4:2]);

    // STAT read sees the value before this cycle's update
    case (ridx)
      R_DIN:   rd_mux = i_DIN;
      R_DOUT:  rd_mux = dout_q;
      R_DDIR:  rd_mux = i_DDIR;
      R_RISE:  rd_mux = rise_en_q;
      R_FALL:  rd_mux = fall_en_q;
      R_STAT:  rd_mux = stat_q;
      R_MASK:  rd_mux = mask_q;
      default: rd_mux = '0;
    endcase

    ready_d   = req;
    rdata_d   = rd ? rd_mux : '0;
    dd_d      = dd_q;
    weo_d     = 1'b0;
    wer_d     = 1'b0;
    dout_d    = dout_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    mask_d    = mask_q;
    clr       = '0;

    if (wr) begin
      case (ridx)
        R_DOUT: begin dout_d = bus.i_WData; dd_d = bus.i_WData; weo_d = 1'b1; end
        R_DDIR: begin dd_d = bus.i_WData; wer_d = 1'b1; end
        R_RISE: rise_en_d = bus.i_WData;
        R_FALL: fall_en_d = bus.i_WData;
        R_STAT: clr       = bus.i_WData;
        R_MASK: mask_d    = bus.i_WData;
        default: ;
      endcase
    end

    prev_d   = i_DIN;
    // prev holds reset value on the first edge; priming suppresses false edges
    primed_d = 1'b1;
  end

  for (genvar a = 0; a < WIDTH; a++) begin : g_lane
    gpio_edge_lane u_lane (
      .primed  (primed_q),
      .din     (i_DIN[a]),
      .prev    (prev_q[a]),
      .ddir    (i_DDIR[a]),
      .rise_en (rise_en_q[a]),
      .fall_en (fall_en_q[a]),
      .stat    (stat_q[a]),
      .clr     (clr[a]),
      .stat_d  (stat_d[a])
    );
  end

  always_comb irq_d = |(stat_d & mask_q);

  always_ff @(posedge i_Clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      dd_q      <= '0;
      weo_q     <= 1'b0;
      wer_q     <= 1'b0;
      dout_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      stat_q    <= '0;
      mask_q    <= '0;
      prev_q    <= '0;
      primed_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      dd_q      <= dd_d;
      weo_q     <= weo_d;
      wer_q     <= wer_d;
      dout_q    <= dout_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      stat_q    <= stat_d;
      mask_q    <= mask_d;
      prev_q    <= prev_d;
      primed_q  <= primed_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.o_RData = rdata_q;
  assign bus.o_Ready = ready_q;
  assign o_DD        = dd_q;
  assign o_WEO       = weo_q;
  assign o_WER       = wer_q;
  assign o_Irq       = irq_q;
endmodule

// File: tb/tb_gpio_bus_bridge.sv
module tb_gpio_bus_bridge;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] din = '0, ddir = '0;
  logic [31:0] dd;
  logic        weo, wer, irq;
  int checks = 0, errors = 0;

  gpio_bus_bridge_if bus ();

  gpio_bus_bridge dut (
    .i_Clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus),
    .i_DIN   (din),
    .i_DDIR  (ddir),
    .o_DD    (dd),
    .o_WEO   (weo),
    .o_WER   (wer),
    .o_Irq   (irq)
  );

  always #5 clk = ~clk;

  // reference model: register file contents and expected outputs
  logic [31:0] m_dout, m_rise, m_fall, m_stat, m_mask, m_prev;
  bit          m_primed;
  logic [31:0] e_rdata, e_dd;
  bit          e_ready, e_weo, e_wer, e_irq;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dout = '0; m_rise = '0; m_fall = '0; m_stat = '0; m_mask = '0; m_prev = '0;
    m_primed = 0;
    e_rdata = '0; e_dd = '0; e_ready = 0; e_weo = 0; e_wer = 0; e_irq = 0;
  endtask

  // what the next clock edge does, given the inputs now on the wires
  task automatic model_step();
    bit req, wr, rd;
    int idx;
    logic [31:0] val, edges, clr, ns;
    req = bus.i_Sel && (bus.i_WE || bus.i_RE);
    wr  = req && bus.i_WE;
    rd  = req && !bus.i_WE;
    idx = int'(bus.i_Addr[4:2]);
    case (idx)
      0: val = din;
      1: val = m_dout;
      2: val = ddir;
      3: val = m_rise;
      4: val = m_fall;
      5: val = m_stat;
      6: val = m_mask;
      default: val = '0;
    endcase
    e_ready = req;
    e_rdata = rd ? val : '0;
    e_weo   = wr && idx == 1;
    e_wer   = wr && idx == 2;
    if (e_weo || e_wer) e_dd = bus.i_WData;
    edges = '0;
    if (m_primed)
      edges = ((din & ~m_prev & m_rise) | (~din & m_prev & m_fall)) & ddir;
    clr = (wr && idx == 5) ? bus.i_WData : '0;
    ns  = (m_stat & ~clr) | edges;
    e_irq = |(ns & m_mask);
    if (wr) begin
      if (idx == 1) m_dout = bus.i_WData;
      if (idx == 3) m_rise = bus.i_WData;
      if (idx == 4) m_fall = bus.i_WData;
      if (idx == 6) m_mask = bus.i_WData;
    end
    m_stat = ns;
    m_prev = din;
    m_primed = 1;
  endtask

  task automatic compare();
    chk("rdata", bus.o_RData, e_rdata);
    chk("ready", {31'b0, bus.o_Ready}, {31'b0, e_ready});
    chk("dd",    dd, e_dd);
    chk("weo",   {31'b0, weo}, {31'b0, e_weo});
    chk("wer",   {31'b0, wer}, {31'b0, e_wer});
    chk("irq",   {31'b0, irq}, {31'b0, e_irq});
  endtask

  task automatic step(bit s, bit w, bit r, logic [4:0] a, logic [31:0] d);
    bus.i_Sel = s; bus.i_WE = w; bus.i_RE = r; bus.i_Addr = a; bus.i_WData = d;
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle();
    step(0, 0, 0, 5'h0, 32'h0);
  endtask

  // reset asserted mid-cycle, optionally while a DOUT write is pending
  task automatic apply_reset(bit wr_pending);
    bus.i_Sel = wr_pending; bus.i_WE = wr_pending; bus.i_RE = 0;
    bus.i_Addr = 5'h04; bus.i_WData = 32'hDEADBEEF;
    #2 rst_n = 0;
    #1;
    model_reset();
    compare();
    @(posedge clk);
    #1;
    compare();
    bus.i_Sel = 0; bus.i_WE = 0;
    rst_n = 1;
  endtask

  initial begin
    bus.i_Sel = 0; bus.i_WE = 0; bus.i_RE = 0; bus.i_Addr = '0; bus.i_WData = '0;
    model_reset();
    apply_reset(0);

    // reset/idle and DIN read
    idle();
    chk("idle_ready", {31'b0, bus.o_Ready}, 32'h0);
    chk("idle_irq",   {31'b0, irq}, 32'h0);
    din = 32'hA5A5A5A5;
    step(1, 0, 1, 5'h00, 32'h0);
    chk("din_ready", {31'b0, bus.o_Ready}, 32'h1);
    chk("din_rdata", bus.o_RData, 32'hA5A5A5A5);
    idle();
    chk("din_rdata_after", bus.o_RData, 32'h0);

    // DOUT / DDIR strobes
    step(1, 1, 0, 5'h04, 32'h12345678);
    chk("weo_pulse", {31'b0, weo}, 32'h1);
    chk("wer_quiet", {31'b0, wer}, 32'h0);
    chk("dd_dout",   dd, 32'h12345678);
    step(1, 0, 1, 5'h04, 32'h0);
    chk("dout_rb", bus.o_RData, 32'h12345678);
    step(1, 1, 0, 5'h08, 32'h0000FFFF);
    chk("wer_pulse", {31'b0, wer}, 32'h1);
    chk("dd_ddir",   dd, 32'h0000FFFF);
    idle();
    chk("wer_drop", {31'b0, wer}, 32'h0);
    chk("dd_hold",  dd, 32'h0000FFFF);

    // rising edge -> STAT + IRQ, then W1C
    ddir = 32'hFFFFFFFF; din = 32'h0;
    step(1, 1, 0, 5'h0C, 32'h1);
    step(1, 1, 0, 5'h18, 32'h1);
    din = 32'h1;
    idle();
    chk("rise_irq", {31'b0, irq}, 32'h1);
    step(1, 0, 1, 5'h14, 32'h0);
    chk("stat_set", bus.o_RData, 32'h1);
    step(1, 1, 0, 5'h14, 32'h1);
    chk("w1c_irq", {31'b0, irq}, 32'h0);
    step(1, 0, 1, 5'h14, 32'h0);
    chk("stat_clr", bus.o_RData, 32'h0);

    // falling edge with FALL_EN=0, and rising edge on output pin
    din = 32'h0;
    idle();
    step(1, 0, 1, 5'h14, 32'h0);
    chk("fall_dis", bus.o_RData, 32'h0);
    ddir = 32'hFFFFFFFE; din = 32'h1;
    idle();
    step(1, 0, 1, 5'h14, 32'h0);
    chk("out_pin", bus.o_RData, 32'h0);
    ddir = 32'hFFFFFFFF; din = 32'h0;
    idle();

    // W1C coincident with a new edge: set wins
    din = 32'h1;
    step(1, 1, 1, 5'h14, 32'h1);
    chk("set_wins_irq", {31'b0, irq}, 32'h1);
    step(1, 0, 1, 5'h14, 32'h0);
    chk("set_wins", bus.o_RData, 32'h1);

    // reset during write, pins high through release
    din = 32'hFFFFFFFF;
    apply_reset(1);
    chk("rst_weo", {31'b0, weo}, 32'h0);
    chk("rst_dd",  dd, 32'h0);
    step(1, 1, 0, 5'h0C, 32'hFFFFFFFF);
    chk("rst_no_weo", {31'b0, weo}, 32'h0);
    idle();
    step(1, 0, 1, 5'h14, 32'h0);
    chk("primed_stat", bus.o_RData, 32'h0);
    step(1, 0, 1, 5'h04, 32'h0);
    chk("rst_dout", bus.o_RData, 32'h0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      din = din ^ ($urandom & $urandom & $urandom);
      if ($urandom_range(0, 31) == 0) ddir = $urandom | $urandom;
      if ($urandom_range(0, 499) == 0) apply_reset($urandom_range(0, 1) == 1);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           5'($urandom), ($urandom_range(0, 1) == 1) ? $urandom : ($urandom & $urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpio_bus_bridge.md
Name: gpio_bus_bridge

Overview:
- Memory-mapped front end that sits between the MIPS data bus and the GPIO block, acting as the bus-side initiator of the GPIO write-enable and data interface.
- Decodes bus loads and stores into registered DOUT/DDIR write strobes, and returns GPIO pin state on reads.
- Adds per-pin rising/falling edge capture with sticky status and a masked interrupt output to the CPU.

Parameters:
- WIDTH, 32, GPIO pin count and bus data width. Fixed at 32 for this design; declared for readability only.
- ADDR_W, 5, byte-address bits decoded inside the block (8 word registers).

Ports:
- i_Clk  input  1  system clock, rising edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_Sel  input  1  chip select from system address decoder
- i_WE  input  1  bus write request (qualified by i_Sel)
- i_RE  input  1  bus read request (qualified by i_Sel)
- i_Addr  input  ADDR_W  byte address; [4:2] selects register, [1:0] ignored
- i_WData  input  WIDTH  bus write data
- o_RData  output  WIDTH  bus read data
- o_Ready  output  1  access complete
- i_DIN  input  WIDTH  sampled pin values from GPIO o_DIN
- i_DDIR  input  WIDTH  direction from GPIO o_DDIR (1 = input)
- o_DD  output  WIDTH  data to GPIO i_DD
- o_WEO  output  1  GPIO output-register write strobe
- o_WER  output  1  GPIO direction-register write strobe
- o_Irq  output  1  interrupt request to CPU, level

Behaviour:
- Reset: every register and output is 0, including o_RData, o_Ready, o_DD, o_WEO, o_WER, o_Irq, DOUT shadow, RISE_EN, FALL_EN, STAT, MASK, prev-pin register and the primed flag. Reset is asynchronous and may occur mid-access; the pending access is dropped with no strobe.
- Register map (word offsets):
  - 0x00 DIN: read-only, returns i_DIN.
  - 0x04 DOUT: write updates the shadow and strobes o_WEO; read returns the shadow.
  - 0x08 DDIR: write strobes o_WER; read returns i_DDIR.
  - 0x0C RISE_EN: read/write.
  - 0x10 FALL_EN: read/write.
  - 0x14 STAT: read returns status; write is W1C.
  - 0x18 MASK: read/write.
  - 0x1C: unmapped; reads 0, writes ignored, o_Ready still asserted.
- Access timing: a request is i_Sel & (i_WE | i_RE) sampled at edge N.
  - o_Ready is high for exactly the following cycle (N+1).
  - o_RData is valid in that cycle and is 0 in every other cycle.
  - Back-to-back requests are accepted every cycle; no wait states.
- i_WE and i_RE both high: treated as a write only; o_RData = 0.
- Write to DOUT or DDIR: in cycle N+1, o_DD = i_WData and the matching strobe (o_WEO or o_WER) is high for one cycle, so GPIO updates at the end of N+1. In all other cycles o_DD holds its last value and both strobes are 0.
- Edge detect:
  - prev <= i_DIN every cycle.
  - primed is set one cycle after reset release. Before primed, no edges are detected.
  - rise[a] = primed & i_DIN[a] & ~prev[a] & i_DDIR[a] & RISE_EN[a].
  - fall[a] = primed & ~i_DIN[a] & prev[a] & i_DDIR[a] & FALL_EN[a].
  - Output-direction pins never set STAT.
- STAT update: STAT <= (STAT & ~clr) | rise | fall, where clr = i_WData on a STAT write, else 0. Set wins over clear in the same cycle.
- o_Irq: registered, o_Irq <= |(STAT_next & MASK); it follows a qualifying edge by one cycle.
- Reads of STAT return the pre-update value.

Test Plan:
- Reset then idle → all outputs 0; reading 0x00 with i_DIN=0xA5A5A5A5 gives o_Ready=1 and o_RData=0xA5A5A5A5 in cycle N+1, and o_RData=0 one cycle later.
- Write 0x04 with data 0x12345678 → N+1: o_WEO=1, o_WER=0, o_DD=0x12345678; read 0x04 returns 0x12345678. Write 0x08 with 0x0000FFFF → one-cycle o_WER pulse with o_DD=0x0000FFFF.
- i_DDIR=0xFFFFFFFF, RISE_EN=0x1, MASK=0x1, pin0 toggles 0→1 → STAT=0x1, o_Irq=1 one cycle later. Write 0x14 with 0x1 → STAT=0, o_Irq drops.
- Same setup with FALL_EN=0 and a pin0 1→0 transition → STAT unchanged. Same edges with i_DDIR[0]=0 → no status bit set.
- W1C of bit0 coincident with a new rising edge on bit0 → STAT[0] stays 1.
- i_DIN=0xFFFFFFFF held through reset release with RISE_EN=all → no STAT bits set. Reset asserted during a write request → no o_WEO/o_WER pulse, all registers 0.
